// File: rtl/uart_rx_dma.sv
// UART receive DMA: deserialises 8N1 frames from rxd and writes each byte
// to consecutive addresses of a byte-wide memory, counting down a length.
module uart_rx_dma #(
  parameter int Clock = 50000000,
  parameter int Baud  = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       start,
  input  logic [7:0] leng,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       wren,
  output logic [7:0] stat,
  output logic       busy,
  output logic       done,
  output logic       ferr
);

  localparam int Div  = Clock / Baud;
  localparam int CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] DivM1  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Div / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [CntW-1:0] cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            err_wait, err_wait_n;
  logic            rx_meta, rxs;
  logic            rx_valid, rx_ferr;
  logic            expire;

  // Two-flop synchronizer for the asynchronous serial input, idles high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receiver state register, baud counter, bit index and shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      err_wait <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      err_wait <= err_wait_n;
    end
  end

  assign expire = (cnt == '0);

  // Receiver next-state: frame timing, sampling and byte/error detection.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    err_wait_n = err_wait;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        // After a framing error the line must return high before a new
        // start edge is honoured, otherwise the low stop bit would retrigger.
        if (err_wait) begin
          if (rxs) err_wait_n = 1'b0;
        end else if (!rxs) begin
          state_n = START;
          cnt_n   = HalfM1;
        end
      end
      START: begin
        if (expire) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            cnt_n     = DivM1;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (expire) begin
          shreg_n = {rxs, shreg[7:1]};
          cnt_n   = DivM1;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (expire) begin
          state_n = IDLE;
          if (rxs) begin
            rx_valid = 1'b1;
          end else begin
            rx_ferr    = 1'b1;
            err_wait_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // DMA bookkeeping: start loads the transfer and overrides any byte
  // completing in the same cycle; the address/count step follows wren.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
      data <= '0;
      wren <= 1'b0;
      stat <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ferr <= 1'b0;
    end else begin
      wren <= 1'b0;
      ferr <= rx_ferr;
      if (start) begin
        stat <= leng;
        addr <= '0;
        done <= (leng == 8'd0);
        busy <= (leng != 8'd0);
      end else begin
        if (wren) begin
          addr <= addr + 8'd1;
          stat <= stat - 8'd1;
          if (stat == 8'd1) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        if (rx_valid && busy) begin
          wren <= 1'b1;
          data <= shreg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_dma.sv
// Testbench for uart_rx_dma: directed table of transfers/frames, a reset
// mid-frame sequence, and randomized frames checked against a transfer model.
module tb_uart_rx_dma;

  localparam int Div = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxd;
  logic       start;
  logic [7:0] leng;
  logic [7:0] addr, data, stat;
  logic       wren, busy, done, ferr;

  uart_rx_dma #(.Clock(160), .Baud(10)) dut (
    .clock(clock), .reset(reset), .rxd(rxd), .start(start), .leng(leng),
    .addr(addr), .data(data), .wren(wren), .stat(stat), .busy(busy),
    .done(done), .ferr(ferr)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Write-strobe and framing-error observations, sampled mid-cycle.
  logic [15:0] wq[$];
  int unsigned fe_seen = 0;
  int unsigned fe_base = 0;

  always @(negedge clock) begin
    if (wren) wq.push_back({addr, data});
    if (ferr) fe_seen++;
  end

  // Transfer model: what the DMA should hold after each start/frame.
  logic [7:0] m_addr, m_data, m_stat;
  logic       m_busy, m_done;

  task automatic m_reset();
    m_addr = 8'h00; m_data = 8'h00; m_stat = 8'h00; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic m_start(input logic [7:0] l);
    m_stat = l; m_addr = 8'h00; m_done = (l == 8'd0); m_busy = (l != 8'd0);
  endtask

  task automatic m_frame(input logic [7:0] d, input logic s,
                         output int unsigned ewr, output logic [7:0] ewa,
                         output int unsigned efe);
    ewr = 0; efe = 0; ewa = 8'h00;
    if (!s) begin
      efe = 1;
    end else if (m_busy) begin
      ewr = 1;
      ewa = m_addr;
      m_data = d;
      m_addr = m_addr + 8'd1;
      m_stat = m_stat - 8'd1;
      if (m_stat == 8'd0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int unsigned ewr,
                             input logic [7:0] ewa, input logic [7:0] ewd,
                             input int unsigned efe, input logic [7:0] ea,
                             input logic [7:0] ed, input logic [7:0] es,
                             input logic eb, input logic edn);
    int unsigned got;
    logic [15:0] w;
    got = wq.size();
    chk({tag, ".nwr"}, got, ewr);
    if (ewr == 1 && got >= 1) begin
      w = wq[0];
      chk({tag, ".waddr"}, {24'h0, w[15:8]}, {24'h0, ewa});
      chk({tag, ".wdata"}, {24'h0, w[7:0]}, {24'h0, ewd});
    end
    chk({tag, ".nferr"}, fe_seen - fe_base, efe);
    chk({tag, ".addr"}, {24'h0, addr}, {24'h0, ea});
    chk({tag, ".data"}, {24'h0, data}, {24'h0, ed});
    chk({tag, ".stat"}, {24'h0, stat}, {24'h0, es});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, eb});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, edn});
    wq.delete();
    fe_base = fe_seen;
  endtask

  // Drive the first nbits of an 8N1 frame (start, 8 data LSB first, stop).
  // Called at a falling edge; returns at a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic s, input int unsigned nbits);
    logic [9:0] fr;
    fr = {s, d, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      rxd = fr[i];
      repeat (Div) @(negedge clock);
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1;
    leng  = l;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
  endtask

  typedef enum {K_START, K_FRAME, K_GLITCH} kind_t;
  typedef struct {
    kind_t       kind;
    logic [7:0]  val;
    logic        stopb;
    int unsigned wr;
    logic [7:0]  waddr;
    int unsigned fe;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  stat;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int unsigned ewr, efe, gap, nfr;
    logic [7:0]  ewa, d, l;
    logic        s;

    // kind, val, stop, wr, waddr, fe, addr, data, stat, busy, done
    tbl.push_back('{K_START,  8'h03, 1'b1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h03, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h55, 1'b1, 1, 8'h00, 0, 8'h01, 8'h55, 8'h02, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'hA3, 1'b1, 1, 8'h01, 0, 8'h02, 8'hA3, 8'h01, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h0F, 1'b1, 1, 8'h02, 0, 8'h03, 8'h0F, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{K_START,  8'h03, 1'b1, 0, 8'h00, 0, 8'h00, 8'h0F, 8'h03, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h11, 1'b1, 1, 8'h00, 0, 8'h01, 8'h11, 8'h02, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h3C, 1'b0, 0, 8'h00, 1, 8'h01, 8'h11, 8'h02, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h22, 1'b1, 1, 8'h01, 0, 8'h02, 8'h22, 8'h01, 1'b1, 1'b0});
    tbl.push_back('{K_GLITCH, 8'h00, 1'b1, 0, 8'h00, 0, 8'h02, 8'h22, 8'h01, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h81, 1'b1, 1, 8'h02, 0, 8'h03, 8'h81, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{K_START,  8'h00, 1'b1, 0, 8'h00, 0, 8'h00, 8'h81, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{K_FRAME,  8'h77, 1'b1, 0, 8'h00, 0, 8'h00, 8'h81, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{K_START,  8'h02, 1'b1, 0, 8'h00, 0, 8'h00, 8'h81, 8'h02, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h44, 1'b1, 1, 8'h00, 0, 8'h01, 8'h44, 8'h01, 1'b1, 1'b0});
    tbl.push_back('{K_START,  8'h04, 1'b1, 0, 8'h00, 0, 8'h00, 8'h44, 8'h04, 1'b1, 1'b0});
    tbl.push_back('{K_FRAME,  8'h99, 1'b1, 1, 8'h00, 0, 8'h01, 8'h99, 8'h03, 1'b1, 1'b0});

    reset = 1'b1; rxd = 1'b1; start = 1'b0; leng = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_state("reset", 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("reset.wren", {31'h0, wren}, 32'h0);
    chk("reset.ferr", {31'h0, ferr}, 32'h0);

    // Directed table; frames with gap 0 are sent back-to-back.
    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_START:  pulse_start(tbl[i].val);
        K_FRAME: begin
          send_frame(tbl[i].val, tbl[i].stopb, 10);
          if (!tbl[i].stopb) repeat (4) @(negedge clock);
        end
        default: begin
          rxd = 1'b0;
          repeat (4) @(negedge clock);
          rxd = 1'b1;
          repeat (20) @(negedge clock);
        end
      endcase
      check_state($sformatf("vec%0d", i), tbl[i].wr, tbl[i].waddr, tbl[i].val,
                  tbl[i].fe, tbl[i].addr, tbl[i].data, tbl[i].stat,
                  tbl[i].busy, tbl[i].done);
    end

    // Reset in the middle of the second byte of a 4-byte transfer.
    pulse_start(8'h04);
    send_frame(8'h5A, 1'b1, 10);
    check_state("rst.first", 1, 8'h00, 8'h5A, 0, 8'h01, 8'h5A, 8'h03, 1'b1, 1'b0);
    send_frame(8'hC6, 1'b1, 5);
    #2 reset = 1'b1;
    #1;
    chk("rst.async.addr", {24'h0, addr}, 32'h0);
    chk("rst.async.data", {24'h0, data}, 32'h0);
    chk("rst.async.stat", {24'h0, stat}, 32'h0);
    chk("rst.async.busy", {31'h0, busy}, 32'h0);
    chk("rst.async.done", {31'h0, done}, 32'h0);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    check_state("rst.after", 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Randomized transfers against the model, including restarts and drops.
    m_reset();
    for (int t = 0; t < 7; t++) begin
      l = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      pulse_start(l);
      m_start(l);
      check_state($sformatf("rnd%0d.start", t), 0, 8'h00, 8'h00, 0,
                  m_addr, m_data, m_stat, m_busy, m_done);
      nfr = int'(l) + 1;
      for (int f = 0; f < int'(nfr); f++) begin
        if (f == 1 && $urandom_range(0, 4) == 0) begin
          l = 8'($urandom_range(1, 3));
          pulse_start(l);
          m_start(l);
          check_state($sformatf("rnd%0d.restart", t), 0, 8'h00, 8'h00, 0,
                      m_addr, m_data, m_stat, m_busy, m_done);
        end
        d = 8'($urandom);
        s = ($urandom_range(0, 7) != 0);
        send_frame(d, s, 10);
        gap = s ? $urandom_range(0, 2) : 4;
        repeat (gap) @(negedge clock);
        m_frame(d, s, ewr, ewa, efe);
        check_state($sformatf("rnd%0d.f%0d", t, f), ewr, ewa, d, efe,
                    m_addr, m_data, m_stat, m_busy, m_done);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
